envelope_bank: RTL and testbench
================================

Name: envelope_bank

Overview:
- Multi-channel, parametrised volume-envelope generator for the sound-chip channel mixers; one instance serves all envelope-bearing channels.
- Each channel ramps its volume up or down by one step every `period` envelope ticks after a trigger, then either holds or repeats.
- Repeat mode, per-channel step strobes and trigger-time latching of settings are new in this generation.
- Runs entirely on the 64 Hz envelope clock, with no other clock domain.

Parameters:
NUM_CH, 4, number of independent envelope channels (>=1)
VOL_W, 4, volume width in bits; max volume = 2^VOL_W-1
PERIOD_W, 3, period field width in bits; period 0 disables stepping

Ports:
clk_64  input  1  envelope clock; all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
trigger  input  NUM_CH  per-channel single-cycle start pulse, synchronous level sampled each edge
envelope_add  input  NUM_CH  per-channel direction: 1 = increment, 0 = decrement
repeat_mode  input  NUM_CH  per-channel: 1 = reload start volume at limit and continue, 0 = hold at limit
period  input  NUM_CH*PERIOD_W  per-channel step period in clk_64 cycles, channel c at [c*PERIOD_W +: PERIOD_W]
starting_volume  input  NUM_CH*VOL_W  per-channel initial volume, channel c at [c*VOL_W +: VOL_W]
volume  output  NUM_CH*VOL_W  per-channel current volume, registered
active  output  NUM_CH  per-channel envelope-running flag, registered
step  output  NUM_CH  one-cycle pulse in the cycle the channel's volume register steps or reloads, registered

Behaviour:
- Reset: volume=0, active=0, step=0, all counters and latched settings=0, for every channel. Reset overrides trigger in the same cycle.
- Channels are fully independent; each has its own latched settings (dir, repeat, period, start), volume register and a PERIOD_W-bit down-counter.
- Trigger on channel c at edge T:
  - Latch envelope_add, repeat_mode, period and starting_volume.
  - Set volume=starting_volume.
  - Load counter=period.
  - Set active=1 if period!=0, else active=0.
  - step=0.
  - Later input changes are ignored until the next trigger.
- Stepping, per edge while active=1 and no trigger:
  - If counter>1: counter decrements.
  - If counter==1: counter reloads the latched period and a step event occurs.
  - First step therefore lands exactly P edges after the trigger edge; subsequent steps land every P edges.
- Step event, add direction:
  - volume<max: volume+1, step=1.
  - volume==max and repeat=0: volume holds, active→0, step=0.
  - volume==max and repeat=1: volume←latched start, step=1, active stays 1.
- Step event, subtract direction:
  - volume>0: volume-1, step=1.
  - volume==0 and repeat=0: hold, active→0, step=0.
  - volume==0 and repeat=1: volume←latched start, step=1.
- Termination occurs at the step event *after* the limit value is reached, so the limit value is held for one full period first.
- Repeat with start equal to the limit: reload to the same value; step still pulses every period and active stays 1.
- Period 0: volume=start held indefinitely, active=0, step never pulses.
- Trigger while active (including in a step-event cycle): trigger wins and the step event is discarded; step=0 that cycle.
- step is high only in the cycle following the edge where volume changed or reloaded; otherwise 0.
- Arithmetic: VOL_W-bit unsigned, never wraps; limit detection is explicit.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert reset 2 cycles while trigger=all 1 → volume=0, active=0, step=0 on all channels; hold reset low, no trigger → outputs unchanged.
- Decay, ch0:
  - Stimulus: start=5, add=0, repeat=0, period=2, trigger.
  - Volume 5→4→3→2→1→0 at edges T+2, T+4, T+6, T+8, T+10, with step pulses there.
  - At T+12: active→0 with no step; volume stays 0 thereafter.
- Repeat attack, ch1:
  - Stimulus: start=13, add=1, repeat=1, period=1.
  - Volume 13,14,15, then 13 on every edge; step high every cycle; active stays 1 for 20 cycles.
- Period 0 and mid-run changes, ch2:
  - Period=0, start=9 → volume=9, active=0, no steps for 16 cycles.
  - Separately, period=3 trigger, then change period input to 1 → steps still every 3 cycles.
- Retrigger collision, ch3:
  - Stimulus: period=1, decreasing from 8; at a step-event cycle, trigger with start=12.
  - Volume=12 next edge; step=0 that edge; next step at +1.
- Independence and parameters:
  - Stimulus: NUM_CH=6, VOL_W=6, PERIOD_W=4; all channels triggered on different edges with period=15, start=63, add=1, repeat=0.
  - Each channel holds 63 for 15 edges, then active→0 without step; no cross-channel interference.

Source files
------------

// File: rtl/envelope_bank_if.sv
// envelope_bank_if: bundle between a channel-mixer controller and the
// envelope bank.
//
// Handshake: there is no backpressure. trigger is a per-channel
// single-cycle start pulse that is sampled on every rising clock edge.
// volume, active and step are registered and valid on every cycle.
//
// Signals:
//   trigger          per-channel start pulse
//   envelope_add     per-channel direction (1 = up, 0 = down)
//   repeat_mode      per-channel repeat (1) / hold (0) at the limit
//   period           per-channel step period, channel c at [c*PERIOD_W +: PERIOD_W]
//   starting_volume  per-channel start volume, channel c at [c*VOL_W +: VOL_W]
//   volume           per-channel current volume
//   active           per-channel envelope-running flag
//   step             per-channel one-cycle step/reload pulse
// Modports: master = controller side, slave = envelope bank side.
interface envelope_bank_if #(
    parameter int NUM_CH   = 4,
    parameter int VOL_W    = 4,
    parameter int PERIOD_W = 3
);
    logic [NUM_CH-1:0]          trigger;
    logic [NUM_CH-1:0]          envelope_add;
    logic [NUM_CH-1:0]          repeat_mode;
    logic [NUM_CH*PERIOD_W-1:0] period;
    logic [NUM_CH*VOL_W-1:0]    starting_volume;
    logic [NUM_CH*VOL_W-1:0]    volume;
    logic [NUM_CH-1:0]          active;
    logic [NUM_CH-1:0]          step;

    modport master (
        output trigger, envelope_add, repeat_mode, period, starting_volume,
        input  volume, active, step
    );

    modport slave (
        input  trigger, envelope_add, repeat_mode, period, starting_volume,
        output volume, active, step
    );
endinterface

// File: rtl/envelope_bank.sv
// envelope_bank: multi-channel volume-envelope generator. It runs on the
// 64 Hz envelope clock.
//
// A trigger on a channel latches that channel's settings and loads the start
// volume. After that the channel steps its volume by one every `period`
// clocks. At the limit (max when adding, 0 when subtracting) the channel
// either stops or reloads the start volume and continues.
//
// Ports:
//   clk_64  envelope clock; all logic on the rising edge
//   reset   synchronous, active-high; clears every channel
//   bus     envelope_bank_if slave modport (inputs: settings and trigger;
//           outputs: volume, active, step, all registered)
module envelope_bank #(
    parameter int NUM_CH   = 4,
    parameter int VOL_W    = 4,
    parameter int PERIOD_W = 3
) (
    input  logic           clk_64,
    input  logic           reset,
    envelope_bank_if.slave bus
);

    localparam logic [VOL_W-1:0]    VOL_MAX = {VOL_W{1'b1}};
    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Input slices for this channel.
        logic                trg_in;
        logic                add_in;
        logic                rpt_in;
        logic [PERIOD_W-1:0] per_in;
        logic [VOL_W-1:0]    start_in;

        // Settings latched at trigger time.
        logic                dir_q;
        logic                rpt_q;
        logic [PERIOD_W-1:0] per_q;
        logic [VOL_W-1:0]    start_q;

        // Running state.
        logic [PERIOD_W-1:0] cnt_q;
        logic [VOL_W-1:0]    vol_q;
        logic                act_q;
        logic                step_q;

        // The limit this channel is heading towards, given its latched direction.
        logic at_limit;

        assign trg_in   = bus.trigger[c];
        assign add_in   = bus.envelope_add[c];
        assign rpt_in   = bus.repeat_mode[c];
        assign per_in   = bus.period[c*PERIOD_W +: PERIOD_W];
        assign start_in = bus.starting_volume[c*VOL_W +: VOL_W];

        assign at_limit = dir_q ? (vol_q == VOL_MAX) : (vol_q == '0);

        always_ff @(posedge clk_64) begin
            if (reset) begin
                dir_q   <= 1'b0;
                rpt_q   <= 1'b0;
                per_q   <= '0;
                start_q <= '0;
                cnt_q   <= '0;
                vol_q   <= '0;
                act_q   <= 1'b0;
                step_q  <= 1'b0;
            end else if (trg_in) begin
                // A trigger takes priority over any step event due this cycle.
                dir_q   <= add_in;
                rpt_q   <= rpt_in;
                per_q   <= per_in;
                start_q <= start_in;
                cnt_q   <= per_in;
                vol_q   <= start_in;
                act_q   <= (per_in != '0);
                step_q  <= 1'b0;
            end else begin
                step_q <= 1'b0;
                if (act_q) begin
                    // While active, the counter is never 0, because a zero
                    // period leaves the channel inactive.
                    if (cnt_q > CNT_ONE) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        cnt_q <= per_q;
                        if (!at_limit) begin
                            vol_q  <= dir_q ? (vol_q + 1'b1) : (vol_q - 1'b1);
                            step_q <= 1'b1;
                        end else if (rpt_q) begin
                            vol_q  <= start_q;
                            step_q <= 1'b1;
                        end else begin
                            // The limit has already been held for one full
                            // period, so the envelope now ends.
                            act_q <= 1'b0;
                        end
                    end
                end
            end
        end

        assign bus.volume[c*VOL_W +: VOL_W] = vol_q;
        assign bus.active[c]                = act_q;
        assign bus.step[c]                  = step_q;
    end

endmodule

// File: tb/tb_envelope_bank.sv
module tb_envelope_bank;

  // ---------------- clock / reset ----------------
  logic clk_64 = 1'b0;
  logic reset;
  always #5 clk_64 = ~clk_64;

  envelope_bank_if #(.NUM_CH(4), .VOL_W(4), .PERIOD_W(3)) ifa ();
  envelope_bank_if #(.NUM_CH(6), .VOL_W(6), .PERIOD_W(4)) ifb ();

  envelope_bank #(.NUM_CH(4), .VOL_W(4), .PERIOD_W(3)) dut_a (
    .clk_64 (clk_64),
    .reset  (reset),
    .bus    (ifa.slave)
  );

  envelope_bank #(.NUM_CH(6), .VOL_W(6), .PERIOD_W(4)) dut_b (
    .clk_64 (clk_64),
    .reset  (reset),
    .bus    (ifb.slave)
  );

  // ---------------- scoreboard ----------------
  // Entry: [15] dut, [14:12] channel, [11:6] volume, [5] active, [4] step, [3:0] test id
  localparam int W = 16;
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  string names[8] = '{"reset", "idle", "decay", "repeat", "period0", "latch", "retrig", "indep"};

  task automatic push(input int d, input int ch, input int v, input int a, input int s, input int t);
    logic [W-1:0] e;
    e = {d[0], ch[2:0], v[5:0], a[0], s[0], t[3:0]};
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, so after each edge it compares
  // every expectation queued for that edge.
  always @(posedge clk_64) begin
    logic [W-1:0] e;
    int ch, ev, ea, es, av, aa, as;
    #1;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ch = int'(e[14:12]);
      ev = int'(e[11:6]);
      ea = int'(e[5]);
      es = int'(e[4]);
      if (e[15] == 1'b0) begin
        av = int'(ifa.volume[ch*4 +: 4]);
        aa = int'(ifa.active[ch]);
        as = int'(ifa.step[ch]);
      end else begin
        av = int'(ifb.volume[ch*6 +: 6]);
        aa = int'(ifb.active[ch]);
        as = int'(ifb.step[ch]);
      end
      checks++;
      if (av != ev || aa != ea || as != es) begin
        errors++;
        $display("FAIL %s dut%0d ch%0d @%0t: got vol=%0d act=%0d step=%0d, expected vol=%0d act=%0d step=%0d",
                 names[e[3:0]], e[15], ch, $time, av, aa, as, ev, ea, es);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(negedge clk_64);
  endtask

  task automatic set_a(input int ch, input logic trg, input logic add, input logic rpt,
                       input logic [2:0] p, input logic [3:0] sv);
    ifa.trigger[ch]               = trg;
    ifa.envelope_add[ch]          = add;
    ifa.repeat_mode[ch]           = rpt;
    ifa.period[ch*3 +: 3]         = p;
    ifa.starting_volume[ch*4 +: 4] = sv;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset                = 1'b1;
    ifa.trigger          = '1;
    ifa.envelope_add     = '1;
    ifa.repeat_mode      = '0;
    ifa.period           = '1;
    ifa.starting_volume  = '1;
    ifb.trigger          = '1;
    ifb.envelope_add     = '1;
    ifb.repeat_mode      = '0;
    ifb.period           = '1;
    ifb.starting_volume  = '1;
    @(negedge clk_64);

    // Reset held two cycles with triggers high: reset must win.
    for (int r = 0; r < 2; r++) begin
      for (int ch = 0; ch < 4; ch++) push(0, ch, 0, 0, 0, 0);
      for (int ch = 0; ch < 6; ch++) push(1, ch, 0, 0, 0, 0);
      next();
    end

    // Out of reset, no triggers: nothing moves.
    reset               = 1'b0;
    ifa.trigger         = '0;
    ifa.period          = '0;
    ifa.starting_volume = '0;
    ifb.trigger         = '0;
    for (int r = 0; r < 3; r++) begin
      for (int ch = 0; ch < 4; ch++) push(0, ch, 0, 0, 0, 1);
      for (int ch = 0; ch < 6; ch++) push(1, ch, 0, 0, 0, 1);
      next();
    end

    // Decay ch0: start 5, down, hold, period 2. Inputs change after the
    // trigger and must be ignored.
    set_a(0, 1'b1, 1'b0, 1'b0, 3'd2, 4'd5);
    push(0, 0, 5, 1, 0, 2);
    next();
    set_a(0, 1'b0, 1'b1, 1'b1, 3'd7, 4'd9);
    for (int k = 1; k <= 14; k++) begin
      if (k <= 10)      push(0, 0, 5 - k/2, 1, (k % 2 == 0) ? 1 : 0, 2);
      else if (k == 11) push(0, 0, 0, 1, 0, 2);
      else              push(0, 0, 0, 0, 0, 2);
      next();
    end

    // Repeat attack ch1: 13, 14, 15, 13, ... with step every cycle.
    set_a(1, 1'b1, 1'b1, 1'b1, 3'd1, 4'd13);
    push(0, 1, 13, 1, 0, 3);
    next();
    set_a(1, 1'b0, 1'b1, 1'b1, 3'd1, 4'd13);
    for (int k = 1; k <= 20; k++) begin
      push(0, 1, 13 + (k % 3), 1, 1, 3);
      next();
    end

    // Period 0 on ch2: start held, inactive, no steps.
    set_a(2, 1'b1, 1'b0, 1'b0, 3'd0, 4'd9);
    push(0, 2, 9, 0, 0, 4);
    next();
    set_a(2, 1'b0, 1'b0, 1'b0, 3'd0, 4'd9);
    for (int k = 1; k <= 16; k++) begin
      push(0, 2, 9, 0, 0, 4);
      next();
    end

    // Period 3 on ch2, then the period input drops to 1: steps stay every 3.
    set_a(2, 1'b1, 1'b0, 1'b0, 3'd3, 4'd10);
    push(0, 2, 10, 1, 0, 5);
    next();
    set_a(2, 1'b0, 1'b0, 1'b0, 3'd1, 4'd10);
    for (int k = 1; k <= 9; k++) begin
      push(0, 2, 10 - k/3, 1, (k % 3 == 0) ? 1 : 0, 5);
      next();
    end

    // Retrigger collision on ch3: period 1 decay from 8, retrigger to 12 on
    // a step-event edge.
    set_a(3, 1'b1, 1'b0, 1'b0, 3'd1, 4'd8);
    push(0, 3, 8, 1, 0, 6);
    next();
    set_a(3, 1'b0, 1'b0, 1'b0, 3'd1, 4'd8);
    for (int k = 1; k <= 3; k++) begin
      push(0, 3, 8 - k, 1, 1, 6);
      next();
    end
    set_a(3, 1'b1, 1'b0, 1'b0, 3'd1, 4'd12);
    push(0, 3, 12, 1, 0, 6);
    next();
    set_a(3, 1'b0, 1'b0, 1'b0, 3'd1, 4'd12);
    push(0, 3, 11, 1, 1, 6);
    next();
    push(0, 3, 10, 1, 1, 6);
    next();

    // Wide instance: staggered triggers, period 15, start at max, add, hold.
    ifb.period          = {6{4'hF}};
    ifb.starting_volume = {6{6'h3F}};
    ifb.envelope_add    = '1;
    ifb.repeat_mode     = '0;
    for (int j = 0; j <= 22; j++) begin
      ifb.trigger = (j < 6) ? 6'(1 << j) : 6'd0;
      for (int c = 0; c < 6; c++) begin
        if (j - c < 0)        push(1, c, 0, 0, 0, 7);
        else if (j - c < 15)  push(1, c, 63, 1, 0, 7);
        else                  push(1, c, 63, 0, 0, 7);
      end
      next();
    end
    ifb.trigger = '0;
    next();
    next();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
